// File: rtl/rx_len_type_decoder.sv
// rx_len_type_decoder
// -------------------
// Frame-header stage of the 10G receive path, sitting directly upstream of the
// receive word counter. It watches the 64-bit receive word stream, picks the
// Length/Type field out of the header and tells the downstream counter how many
// data words to expect and when to count them.
//
// Byte lane n of a word is rxd64[8n+7:8n]; lane 0 is the first byte on the wire.
// W0 carries DA0..SA1 (flagged by frame_start), and W1 carries the L/T field
// in lanes 4/5. When that field equals TPID, the real L/T sits in lanes 0/1 of W2.
//
// Ports
//   rxclk, reset        receive clock, synchronous active-high reset
//   rxd64, rx_valid     receive word and its qualifier
//   frame_start         first word of a frame (implies rx_valid)
//   frame_end           last word of a frame
//   end_data_cnt        downstream counter has used up the aligned data words
//   start_data_cnt      level, high for the whole data phase
//   start_tagged_cnt    level, high for the whole data phase of a tagged frame
//   tagged_frame        frame carries the VLAN TPID
//   small_frame         length field is below the minimum data size
//   len_valid           L/T field is a length (<= MAX_LEN)
//   integer_cnt         full words in the padded data field
//   small_integer_cnt   full words in the unpadded data field
//   data_frac           trailing bytes of the padded data field
//   small_frac          trailing bytes of the unpadded data field
//   len_err             frame/length inconsistency pulse
//
// Build option
//   RX_LEN_CHECK_EN  when defined, len_err pulses for one cycle after a frame_end
//                    that contradicts a valid length field. This happens if the
//                    frame ends in the header, or if it ends in the data phase
//                    before end_data_cnt. When not defined, len_err is tied low.

module rx_len_type_decoder #(
    parameter int          CNT_WIDTH = 13,
    parameter int          MIN_DATA  = 46,
    parameter int          MAX_LEN   = 1500,
    parameter logic [15:0] TPID      = 16'h8100
) (
    input  logic                 rxclk,
    input  logic                 reset,
    input  logic [63:0]          rxd64,
    input  logic                 rx_valid,
    input  logic                 frame_start,
    input  logic                 frame_end,
    input  logic                 end_data_cnt,
    output logic                 start_data_cnt,
    output logic                 start_tagged_cnt,
    output logic                 tagged_frame,
    output logic                 small_frame,
    output logic                 len_valid,
    output logic [CNT_WIDTH-1:0] integer_cnt,
    output logic [CNT_WIDTH-1:0] small_integer_cnt,
    output logic [2:0]           data_frac,
    output logic [2:0]           small_frac,
    output logic                 len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR1 = 2'd1,
        TAG  = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]          lt_w1;
    logic [15:0]          lt_w2;
    logic [15:0]          lt_sel;
    logic [31:0]          lt_ext;
    logic [31:0]          min_ext;
    logic [31:0]          pad_ext;
    logic                 dec_load;
    logic                 set_tag;
    logic                 clear_hdr;
    logic                 dec_len_valid;
    logic                 dec_small;
    logic [CNT_WIDTH-1:0] dec_int;
    logic [CNT_WIDTH-1:0] dec_small_int;
    logic [2:0]           dec_frac;
    logic [2:0]           dec_small_frac;

    // Payload bytes outside the L/T lanes never affect this stage.
    logic unused_payload;
    assign unused_payload = ^{rxd64[63:48], rxd64[31:16]};

    // L/T is big-endian on the wire: the earlier lane is the high byte.
    assign lt_w1 = {rxd64[39:32], rxd64[47:40]};
    assign lt_w2 = {rxd64[7:0], rxd64[15:8]};

    // State register.
    always_ff @(posedge rxclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and header strobes. Nothing moves unless rx_valid is
    // high. A frame_end forces IDLE from anywhere, and a frame_start overrides
    // everything, because the word carrying it is W0 of a fresh frame.
    always_comb begin
        state_next       = state;
        dec_load         = 1'b0;
        set_tag          = 1'b0;
        clear_hdr        = 1'b0;
        lt_sel           = lt_w1;
        min_ext          = 32'(MIN_DATA);
        start_data_cnt   = (state == DATA);
        start_tagged_cnt = (state == DATA) && tagged_frame;

        if (rx_valid) begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                HDR1: begin
                    if (lt_w1 == TPID) begin
                        state_next = TAG;
                        set_tag    = !frame_end;
                    end else begin
                        state_next = DATA;
                        dec_load   = 1'b1;
                    end
                end
                TAG: begin
                    lt_sel     = lt_w2;
                    min_ext    = 32'(MIN_DATA - 4);
                    dec_load   = 1'b1;
                    state_next = DATA;
                end
                DATA: begin
                    if (end_data_cnt && len_valid) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            if (frame_end) begin
                state_next = IDLE;
            end

            if (frame_start) begin
                state_next = HDR1;
                clear_hdr  = 1'b1;
                dec_load   = 1'b0;
                set_tag    = 1'b0;
            end
        end
    end

    // L/T decode of the currently selected field. The length is zero-extended
    // so that every comparison is unsigned. Type values (anything above MAX_LEN,
    // including the 1501..TPID-1 gap) report "no length" as all-ones counts.
    always_comb begin
        lt_ext         = {16'd0, lt_sel};
        dec_len_valid  = (lt_ext <= 32'(MAX_LEN));
        dec_small      = 1'b0;
        pad_ext        = lt_ext;
        dec_int        = '1;
        dec_small_int  = '1;
        dec_frac       = 3'd0;
        dec_small_frac = 3'd0;

        if (dec_len_valid) begin
            dec_small      = (lt_ext < min_ext);
            pad_ext        = dec_small ? min_ext : lt_ext;
            dec_int        = CNT_WIDTH'(pad_ext >> 3);
            dec_frac       = pad_ext[2:0];
            dec_small_int  = CNT_WIDTH'(lt_ext >> 3);
            dec_small_frac = lt_ext[2:0];
        end
    end

    // Per-frame header results. These hold through the data phase and past the
    // end of the frame, and are cleared back to reset values by the next frame_start.
    always_ff @(posedge rxclk) begin
        if (reset || clear_hdr) begin
            tagged_frame      <= 1'b0;
            small_frame       <= 1'b0;
            len_valid         <= 1'b0;
            integer_cnt       <= '1;
            small_integer_cnt <= '1;
            data_frac         <= 3'd0;
            small_frac        <= 3'd0;
        end else begin
            if (set_tag) begin
                tagged_frame <= 1'b1;
            end
            if (dec_load) begin
                small_frame       <= dec_small;
                len_valid         <= dec_len_valid;
                integer_cnt       <= dec_int;
                small_integer_cnt <= dec_small_int;
                data_frac         <= dec_frac;
                small_frac        <= dec_small_frac;
            end
        end
    end

`ifdef RX_LEN_CHECK_EN
    // Length validity as it stands for the word being accepted. In the header
    // states the decode of that very word is used. In DATA the stored result
    // is used.
    logic check_len_valid;

    always_comb begin
        check_len_valid = len_valid;
        if (dec_load) begin
            check_len_valid = dec_len_valid;
        end
    end

    // A valid length promised more data than the frame delivered. That covers
    // an end inside the header, and an end in DATA without end_data_cnt. A
    // matching end_data_cnt already moves DATA to IDLE, so a frame_end after
    // it arrives in IDLE and is not checked.
    always_ff @(posedge rxclk) begin
        if (reset) begin
            len_err <= 1'b0;
        end else begin
            len_err <= rx_valid && frame_end && !frame_start && check_len_valid &&
                       ((state == HDR1) || (state == TAG) ||
                        ((state == DATA) && !end_data_cnt));
        end
    end
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_len_type_decoder.sv
// tb_rx_len_type_decoder
// ----------------------
// Directed bench for rx_len_type_decoder. The stimulus thread drives words and
// queues the outputs it expects, each stamped with the clock cycle in which it
// should be visible. A separate monitor pops the entries on the falling edge and
// compares them.
// Flag vectors are ordered {start_data_cnt, start_tagged_cnt, tagged_frame,
// small_frame, len_valid, len_err}.

module tb_rx_len_type_decoder;

    localparam int CW = 13;
    localparam logic [CW-1:0] ONES = '1;

`ifdef RX_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          rxclk;
    logic          reset;
    logic [63:0]   rxd64;
    logic          rx_valid;
    logic          frame_start;
    logic          frame_end;
    logic          end_data_cnt;
    logic          start_data_cnt;
    logic          start_tagged_cnt;
    logic          tagged_frame;
    logic          small_frame;
    logic          len_valid;
    logic [CW-1:0] integer_cnt;
    logic [CW-1:0] small_integer_cnt;
    logic [2:0]    data_frac;
    logic [2:0]    small_frac;
    logic          len_err;

    rx_len_type_decoder dut (
        .rxclk             (rxclk),
        .reset             (reset),
        .rxd64             (rxd64),
        .rx_valid          (rx_valid),
        .frame_start       (frame_start),
        .frame_end         (frame_end),
        .end_data_cnt      (end_data_cnt),
        .start_data_cnt    (start_data_cnt),
        .start_tagged_cnt  (start_tagged_cnt),
        .tagged_frame      (tagged_frame),
        .small_frame       (small_frame),
        .len_valid         (len_valid),
        .integer_cnt       (integer_cnt),
        .small_integer_cnt (small_integer_cnt),
        .data_frac         (data_frac),
        .small_frac        (small_frac),
        .len_err           (len_err)
    );

    typedef struct {
        int            cyc;
        string         name;
        logic [5:0]    flags;
        logic [5:0]    mask;
        bit            chk_cnt;
        logic [CW-1:0] ic;
        logic [CW-1:0] sic;
        logic [2:0]    df;
        logic [2:0]    sf;
    } exp_t;

    exp_t exp_q[$];
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;

    localparam logic [63:0] DWORD = 64'h0123_4567_89AB_CDEF;

    // Clock generation.
    initial begin
        rxclk = 1'b0;
        forever #5 rxclk = ~rxclk;
    end

    // Cycle stamp used to line expectations up with the monitor.
    always @(posedge rxclk) begin
        cyc <= cyc + 1;
    end

    // W1-style word: L/T in lanes 4 (high byte) and 5 (low byte).
    function automatic logic [63:0] lt_word(input logic [15:0] lt);
        logic [63:0] w;
        w = 64'hA5A5_0000_A5A5_A5A5;
        w[39:32] = lt[15:8];
        w[47:40] = lt[7:0];
        return w;
    endfunction

    // W2-style word: L/T in lanes 0 (high byte) and 1 (low byte).
    function automatic logic [63:0] w2_word(input logic [15:0] lt);
        logic [63:0] w;
        w = 64'h5A5A_5A5A_5A5A_0000;
        w[7:0]  = lt[15:8];
        w[15:8] = lt[7:0];
        return w;
    endfunction

    // Drive one word, let one rising edge consume it, and settle just after.
    task automatic applyStimulus(input logic [63:0] d, input logic v, input logic fs,
                                 input logic fe, input logic edc);
        rxd64        = d;
        rx_valid     = v;
        frame_start  = fs;
        frame_end    = fe;
        end_data_cnt = edc;
        @(posedge rxclk);
        #1;
    endtask

    task automatic expect_full(input string name, input logic [5:0] flags,
                               input logic [CW-1:0] ic, input logic [CW-1:0] sic,
                               input logic [2:0] df, input logic [2:0] sf);
        exp_t e;
        e.cyc = cyc; e.name = name; e.flags = flags; e.mask = 6'b111111;
        e.chk_cnt = 1'b1; e.ic = ic; e.sic = sic; e.df = df; e.sf = sf;
        exp_q.push_back(e);
    endtask

    task automatic expect_flags(input string name, input logic [5:0] flags);
        exp_t e;
        e.cyc = cyc; e.name = name; e.flags = flags; e.mask = 6'b111111;
        e.chk_cnt = 1'b0; e.ic = '0; e.sic = '0; e.df = '0; e.sf = '0;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [5:0] act;
        bit         bad;
        act = {start_data_cnt, start_tagged_cnt, tagged_frame, small_frame, len_valid, len_err};
        bad = ((act & e.mask) !== (e.flags & e.mask));
        if (e.chk_cnt && ({integer_cnt, small_integer_cnt, data_frac, small_frac} !==
                          {e.ic, e.sic, e.df, e.sf}))
            bad = 1'b1;
        compared++;
        if (bad) begin
            mismatched++;
            $display("[TB] FAIL %s: got flags=%b ic=%0d sic=%0d df=%0d sf=%0d, want flags=%b ic=%0d sic=%0d df=%0d sf=%0d (counts checked=%0d)",
                     e.name, act, integer_cnt, small_integer_cnt, data_frac, small_frac,
                     e.flags, e.ic, e.sic, e.df, e.sf, e.chk_cnt);
        end
    endtask

    // Monitor: compare every expectation due in this cycle.
    always @(negedge rxclk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            if (exp_q[0].cyc < cyc) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL %s: missed, due cycle %0d, now %0d", exp_q[0].name,
                         exp_q[0].cyc, cyc);
            end else begin
                checkOutput(exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        rxd64 = '0; rx_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0; end_data_cnt = 1'b0;
        applyStimulus('0, 0, 0, 0, 0);
        applyStimulus('0, 0, 0, 0, 0);
        expect_full("reset", 6'b000000, ONES, ONES, 3'd0, 3'd0);
        reset = 1'b0;
        applyStimulus('0, 0, 0, 0, 0);

        // Untagged length 100: pad 100 -> 12 words + 4 bytes.
        applyStimulus(lt_word(16'h8100), 1, 1, 0, 0);
        expect_flags("a_hdr1", 6'b000000);
        applyStimulus(lt_word(16'h0064), 1, 0, 0, 0);
        expect_full("a_decode", 6'b100010, 13'd12, 13'd12, 3'd4, 3'd4);
        applyStimulus(DWORD, 1, 0, 0, 0);
        expect_flags("a_data", 6'b100010);
        applyStimulus(DWORD, 1, 0, 0, 1);
        expect_full("a_end_data", 6'b000010, 13'd12, 13'd12, 3'd4, 3'd4);
        applyStimulus(DWORD, 1, 0, 1, 0);
        expect_full("a_frame_end", 6'b000010, 13'd12, 13'd12, 3'd4, 3'd4);

        // Tagged, inner length 16 with tagged minimum 42.
        applyStimulus(lt_word(16'h8100), 1, 1, 0, 0);
        expect_flags("c_hdr1", 6'b000000);
        applyStimulus(lt_word(16'h8100), 1, 0, 0, 0);
        expect_flags("c_tag", 6'b001000);
        applyStimulus(w2_word(16'h0010), 1, 0, 0, 0);
        expect_full("c_decode", 6'b111110, 13'd5, 13'd2, 3'd2, 3'd0);
        applyStimulus(DWORD, 1, 0, 0, 0);
        expect_flags("c_data", 6'b111110);
        // Restart mid-data: new frame clears the tagged frame's results.
        applyStimulus(lt_word(16'h8100), 1, 1, 0, 0);
        expect_flags("c_restart", 6'b000000);

        // Untagged length 20: pad 46 -> 5+6, unpadded 2+4, small frame.
        applyStimulus(lt_word(16'h0014), 1, 0, 0, 0);
        expect_full("b_decode", 6'b100110, 13'd5, 13'd2, 3'd6, 3'd4);
        applyStimulus(DWORD, 1, 0, 0, 1);
        expect_full("b_end_data", 6'b000110, 13'd5, 13'd2, 3'd6, 3'd4);
        applyStimulus(DWORD, 1, 0, 1, 0);
        expect_flags("b_frame_end", 6'b000110);

        // Type frame 0x0800: end_data_cnt ignored, frame_end ends data.
        applyStimulus(lt_word(16'h0000), 1, 1, 0, 0);
        applyStimulus(lt_word(16'h0800), 1, 0, 0, 0);
        expect_full("d_decode", 6'b100000, ONES, ONES, 3'd0, 3'd0);
        applyStimulus(DWORD, 1, 0, 0, 1);
        expect_flags("d_edc_ignored", 6'b100000);
        applyStimulus(DWORD, 1, 0, 1, 0);
        expect_full("d_frame_end", 6'b000000, ONES, ONES, 3'd0, 3'd0);

        // Gaps between W0 and W1: invalid words carry a TPID that must be ignored.
        applyStimulus(DWORD, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(lt_word(16'h8100), 0, 0, 0, 0);
            expect_flags("e_hold", 6'b000000);
        end
        applyStimulus(lt_word(16'h0064), 1, 0, 0, 0);
        expect_full("e_decode", 6'b100010, 13'd12, 13'd12, 3'd4, 3'd4);
        applyStimulus(DWORD, 1, 0, 0, 0);
        expect_flags("e_data", 6'b100010);
        reset = 1'b1;
        applyStimulus(DWORD, 1, 0, 0, 0);
        expect_full("e_reset", 6'b000000, ONES, ONES, 3'd0, 3'd0);
        reset = 1'b0;

        // Frame right after reset, ending early in DATA without end_data_cnt.
        applyStimulus(lt_word(16'h8100), 1, 1, 0, 0);
        expect_flags("g_hdr1", 6'b000000);
        applyStimulus(lt_word(16'h0064), 1, 0, 0, 0);
        expect_full("g_decode", 6'b100010, 13'd12, 13'd12, 3'd4, 3'd4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(DWORD, 1, 0, 0, 0);
            expect_flags("g_data", 6'b100010);
        end
        applyStimulus(DWORD, 1, 0, 1, 0);
        expect_full("g_len_err", {5'b00001, CHK}, 13'd12, 13'd12, 3'd4, 3'd4);
        applyStimulus('0, 0, 0, 0, 0);
        expect_flags("g_len_err_once", 6'b000010);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge rxclk);
        end
        repeat (2) @(posedge rxclk);
        while (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: never checked, due cycle %0d", exp_q[0].name, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rx_len_type_decoder.md
Name: rx_len_type_decoder

Overview:
- Frame-header stage of the 10G receive path. Sits directly upstream of the receive word counter.
- Parses the 64-bit receive word stream: takes the DA/SA words, detects a VLAN tag and decodes the Length/Type field.
- Produces the counter controls (start_data_cnt, start_tagged_cnt, small_frame, tagged_frame) and the word counts (integer_cnt, small_integer_cnt). The downstream counter's end_data_cnt terminates the data phase.

Parameters:
CNT_WIDTH, 13, width of the word-count outputs
MIN_DATA, 46, minimum untagged data-field bytes; the tagged minimum is MIN_DATA-4
MAX_LEN, 1500, largest L/T value treated as a length
TPID, 16'h8100, VLAN tag protocol identifier

Ports:
rxclk  in  1  receive clock
reset  in  1  synchronous, active-high reset
rxd64  in  64  received word; byte lane 0 = rxd64[7:0] = first byte on wire
rx_valid  in  1  rxd64 holds a frame word this cycle
frame_start  in  1  pulse with the first word (DA0..SA1); implies rx_valid
frame_end  in  1  pulse with the last frame word
end_data_cnt  in  1  from downstream counter: aligned data words exhausted
start_data_cnt  out  1  data-field counting enable (level)
start_tagged_cnt  out  1  tagged-frame counting enable (level)
tagged_frame  out  1  current frame carries TPID
small_frame  out  1  length field < minimum data size
len_valid  out  1  L/T field is a length (<= MAX_LEN)
integer_cnt  out  CNT_WIDTH  full 64-bit words in the padded data field
small_integer_cnt  out  CNT_WIDTH  full 64-bit words in the unpadded data field
data_frac  out  3  trailing bytes of the padded data field
small_frac  out  3  trailing bytes of the unpadded data field
len_err  out  1  see Optional Feature

Behaviour:
- Interface: single clock rxclk. Reset is synchronous, active-high, on port reset.
- Reset: state=IDLE. All outputs 0, except integer_cnt and small_integer_cnt, which reset to all-ones.
- Reset mid-frame aborts the frame. The next frame_start is honoured on the first cycle after reset is released.
- Word indexing: W0 = bytes 0-7, W1 = bytes 8-15, W2 = bytes 16-23.
- L/T location:
  - L/T = {W1 lane4, W1 lane5}.
  - If L/T == TPID, the real L/T = {W2 lane0, W2 lane1}.
- State machine (advances only when rx_valid=1; otherwise holds):
  - IDLE -> HDR1 on frame_start.
  - HDR1 (W1 present):
    - L/T==TPID -> TAG.
    - Otherwise -> DATA, and decode L/T with min=MIN_DATA.
  - TAG (W2 present): decode W2 L/T with min=MIN_DATA-4, then -> DATA.
  - DATA -> IDLE on frame_end, or on end_data_cnt when len_valid=1.
  - Any state -> IDLE on frame_end. A frame_start in the same cycle takes priority and goes to HDR1.
- Decode (registered, visible the cycle after W1 or W2 is accepted):
  - len_valid = (L/T <= MAX_LEN).
  - If len_valid:
    - pad = max(L/T, min).
    - integer_cnt = pad>>3; data_frac = pad[2:0].
    - small_integer_cnt = L/T>>3; small_frac = L/T[2:0].
    - small_frame = (L/T < min).
  - If not len_valid (type frame, or 1501..TPID-1 excluding TPID):
    - integer_cnt = small_integer_cnt = all-ones.
    - fracs = 0; small_frame = 0.
  - All arithmetic is unsigned. The 16-bit L/T is zero-extended before comparison.
- Outputs in DATA state:
  - start_data_cnt = 1 for the whole DATA state.
  - start_tagged_cnt = tagged_frame, for the whole DATA state.
  - Both deassert in the cycle after the DATA exit condition.
- Hold and clear:
  - tagged_frame is set on the TAG transition.
  - tagged_frame, small_frame, len_valid and the counts hold until the next frame_start, then clear at HDR1.
- Short or aborted frames:
  - frame_end in HDR1 or TAG -> IDLE with no start_* assertion.
  - A frame_start while not in IDLE restarts the frame at HDR1.

Optional Feature:
- Macro: RX_LEN_CHECK_EN.
- Defined:
  - len_err pulses for 1 cycle after frame_end when len_valid=1 and the frame is inconsistent with the length.
  - Inconsistent means either of:
    - frame_end arrives in HDR1 or TAG;
    - frame_end arrives in DATA before end_data_cnt has been seen for this frame.
  - len_err is cleared by reset.
- Not defined: len_err is tied to 0 and no check logic is built.

Test Plan:
- Untagged, L/T=0x0064 (100): start_data_cnt=1 one cycle after W1 -> integer_cnt=12, data_frac=4, small_frame=0, start_tagged_cnt=0; end_data_cnt -> start_data_cnt=0 next cycle.
- Untagged, L/T=0x0014 (20) -> small_frame=1, integer_cnt=5, data_frac=6, small_integer_cnt=2, small_frac=4.
- W1 L/T=0x8100, W2 L/T=0x0010 (16) -> tagged_frame=1, start_tagged_cnt=start_data_cnt=1 after W2, integer_cnt=5, data_frac=2, small_integer_cnt=2, small_frac=0, small_frame=1.
- Type frame L/T=0x0800 -> len_valid=0, integer_cnt=13'h1FFF; end_data_cnt ignored; start_data_cnt drops only after frame_end.
- rx_valid=0 for 3 cycles between W0 and W1 -> state holds in HDR1, decode unchanged; reset asserted in DATA -> all outputs 0 next cycle.
- With RX_LEN_CHECK_EN: L/T=0x0064, frame_end 4 words into DATA without end_data_cnt -> len_err=1 for exactly 1 cycle; without the macro -> len_err stays 0.
